// File: rtl/abro_pkg.sv
// Shared ABRO encodings, drive payload and the reference next-state function
// used by both the ABRO DUT and the stimulus driver's internal model.
package abro_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_A    = 2'b01,
      S_B    = 2'b10,
      S_DONE = 2'b11
   } state_t;

   typedef enum logic {
      P_IDLE = 1'b0,
      P_PLAY = 1'b1
   } player_t;

   typedef struct packed {
      logic a;
      logic b;
      logic r;
   } drive_t;

   localparam int unsigned DRIVE_W = $bits(drive_t);

   // R has priority; otherwise each input only moves the machine toward S_DONE.
   function automatic state_t abro_next(input state_t s, input logic a,
                                        input logic b, input logic r);
      state_t n;
      n = s;
      if (r) begin
         n = S_IDLE;
      end else begin
         case (s)
            S_IDLE: begin
               if (a && b)  n = S_DONE;
               else if (a)  n = S_A;
               else if (b)  n = S_B;
            end
            S_A:     if (b) n = S_DONE;
            S_B:     if (a) n = S_DONE;
            default: n = s;
         endcase
      end
      return n;
   endfunction

endpackage

// File: rtl/abro_cmd_fifo.sv
// Synchronous command FIFO with show-ahead read data so a pop and a load of
// the popped entry can happen on the same clock edge.
module abro_cmd_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 11
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign rdata   = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/abro_stim_driver.sv
// ABRO stimulus/response driver: plays timed A/B/R commands from a FIFO and
// checks the DUT's O/State against an internal reference model every played cycle.
module abro_stim_driver
   import abro_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned HOLDW = 8,
   parameter int unsigned CNTW  = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_a,
   input  logic             cmd_b,
   input  logic             cmd_r,
   input  logic [HOLDW-1:0] cmd_hold,
   output logic             A,
   output logic             B,
   output logic             R,
   input  logic             dut_O,
   input  logic [1:0]       dut_State,
   output logic             busy,
   output logic [CNTW-1:0]  cycle_cnt,
   output logic [CNTW-1:0]  err_cnt,
   output logic             err,
   output logic [CNTW-1:0]  err_cycle,
   output logic [1:0]       exp_State
);

   localparam int unsigned   FW      = DRIVE_W + HOLDW;
   localparam logic [CNTW-1:0] CNT_MAX = '1;

   player_t          state_q, state_d;
   drive_t           drv_q, drv_d;
   logic [HOLDW-1:0] hold_q, hold_d;
   logic             post_q, post_d;
   state_t           model_q, model_d;

   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [FW-1:0]    fifo_rdata;
   drive_t           fifo_drv;
   logic [HOLDW-1:0] fifo_hold;
   logic             chk;
   logic             mis;

   abro_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FW)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (cmd_valid && cmd_ready),
      .pop     (pop),
      .wdata   ({cmd_a, cmd_b, cmd_r, cmd_hold}),
      .rdata   (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign fifo_drv  = fifo_rdata[FW-1 -: DRIVE_W];
   assign fifo_hold = fifo_rdata[HOLDW-1:0];

   assign cmd_ready = !fifo_full;
   assign busy      = (state_q != P_IDLE) || !fifo_empty;
   assign A         = drv_q.a;
   assign B         = drv_q.b;
   assign R         = drv_q.r;
   assign exp_State = model_q;

   // Player: load on idle or on the last hold cycle so commands play back-to-back.
   always_comb begin
      state_d = state_q;
      drv_d   = drv_q;
      hold_d  = hold_q;
      post_d  = 1'b0;
      pop     = 1'b0;
      case (state_q)
         P_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               drv_d   = fifo_drv;
               hold_d  = (fifo_hold == '0) ? HOLDW'(1) : fifo_hold;
               state_d = P_PLAY;
            end
         end
         P_PLAY: begin
            if (hold_q <= HOLDW'(1)) begin
               if (!fifo_empty) begin
                  pop    = 1'b1;
                  drv_d  = fifo_drv;
                  hold_d = (fifo_hold == '0) ? HOLDW'(1) : fifo_hold;
               end else begin
                  drv_d   = '0;
                  hold_d  = '0;
                  post_d  = 1'b1;
                  state_d = P_IDLE;
               end
            end else begin
               hold_d = hold_q - HOLDW'(1);
            end
         end
         default: state_d = P_IDLE;
      endcase
   end

   // Checking covers every played cycle plus the response to the final drive.
   always_comb begin
      model_d = abro_next(model_q, drv_q.a, drv_q.b, drv_q.r);
      chk     = (state_q == P_PLAY) || post_q;
      mis     = chk && ((dut_O != (model_q == S_DONE)) || (dut_State != model_q));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= P_IDLE;
         drv_q     <= '0;
         hold_q    <= '0;
         post_q    <= 1'b0;
         model_q   <= S_IDLE;
         cycle_cnt <= '0;
         err_cnt   <= '0;
         err       <= 1'b0;
         err_cycle <= '0;
      end else begin
         state_q <= state_d;
         drv_q   <= drv_d;
         hold_q  <= hold_d;
         post_q  <= post_d;
         model_q <= model_d;
         if (chk && (cycle_cnt != CNT_MAX)) cycle_cnt <= cycle_cnt + CNTW'(1);
         if (mis) begin
            if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNTW'(1);
            if (!err) begin
               err       <= 1'b1;
               err_cycle <= cycle_cnt;
            end
         end
      end
   end

endmodule

// File: tb/tb_abro_stim_driver.sv
// Bench for abro_stim_driver: an ABRO DUT with a State fault switch, a queue-based
// model of playback/checking compared every cycle, and literal spot checks.
module tb_abro_stim_driver;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned HOLDW = 8;
   localparam int unsigned CNTW  = 16;
   localparam int          CMAX  = (1 << CNTW) - 1;

   logic             clk       = 1'b0;
   logic             reset_n   = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic             cmd_a     = 1'b0;
   logic             cmd_b     = 1'b0;
   logic             cmd_r     = 1'b0;
   logic [HOLDW-1:0] cmd_hold  = '0;
   logic             A, B, R;
   logic             dut_O;
   logic [1:0]       dut_State;
   logic             busy;
   logic [CNTW-1:0]  cycle_cnt, err_cnt, err_cycle;
   logic             err;
   logic [1:0]       exp_State;

   logic [1:0]       abro_st;
   logic             force_zero = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   abro_stim_driver #(.DEPTH(DEPTH), .HOLDW(HOLDW), .CNTW(CNTW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_r     (cmd_r),
      .cmd_hold  (cmd_hold),
      .A         (A),
      .B         (B),
      .R         (R),
      .dut_O     (dut_O),
      .dut_State (dut_State),
      .busy      (busy),
      .cycle_cnt (cycle_cnt),
      .err_cnt   (err_cnt),
      .err       (err),
      .err_cycle (err_cycle),
      .exp_State (exp_State)
   );

   // ABRO DUT as "which of A/B has been seen since R": bit0 = A, bit1 = B.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  abro_st <= 2'b00;
      else if (R)    abro_st <= 2'b00;
      else           abro_st <= abro_st | {B, A};
   end
   assign dut_O     = (abro_st == 2'b11);
   assign dut_State = force_zero ? 2'b00 : abro_st;

   // ---------------- behavioural model ----------------
   typedef struct {
      logic a;
      logic b;
      logic r;
      int   hold;
   } cmd_s;

   cmd_s       q[$];
   cmd_s       cur;
   bit         m_play = 1'b0;
   bit         m_post = 1'b0;
   int         m_rem = 0;
   logic       m_a = 1'b0, m_b = 1'b0, m_r = 1'b0;
   logic [1:0] m_st = 2'b00;
   int         m_cyc = 0, m_errcnt = 0, m_errcyc = 0;
   bit         m_err = 1'b0;
   bit         push_ok;
   bit         bad_now;

   initial begin
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            q.delete();
            m_play = 0; m_post = 0; m_rem = 0;
            m_a = 0; m_b = 0; m_r = 0; m_st = 2'b00;
            m_cyc = 0; m_errcnt = 0; m_errcyc = 0; m_err = 0;
         end else begin
            push_ok = cmd_valid && (q.size() < DEPTH);
            if (m_play || m_post) begin
               bad_now = (dut_State != m_st) || (dut_O != (m_st == 2'b11));
               if (bad_now) begin
                  if (!m_err) begin m_err = 1; m_errcyc = m_cyc; end
                  if (m_errcnt < CMAX) m_errcnt++;
               end
               if (m_cyc < CMAX) m_cyc++;
            end
            m_st   = m_r ? 2'b00 : (m_st | {m_b, m_a});
            m_post = 0;
            if (m_play && m_rem > 1) begin
               m_rem--;
            end else if (q.size() > 0) begin
               cur = q.pop_front();
               m_a = cur.a; m_b = cur.b; m_r = cur.r;
               m_rem  = (cur.hold == 0) ? 1 : cur.hold;
               m_play = 1;
            end else begin
               m_post = m_play;
               m_play = 0;
               m_a = 0; m_b = 0; m_r = 0;
            end
            if (push_ok) begin
               cur.a = cmd_a; cur.b = cmd_b; cur.r = cmd_r; cur.hold = int'(cmd_hold);
               q.push_back(cur);
            end
         end
      end
   end

   // ---------------- comparison helpers ----------------
   task automatic check_cycle();
      bit ok;
      ok = ({A, B, R} == {m_a, m_b, m_r}) && (busy == (m_play || q.size() != 0)) &&
           (cmd_ready == (q.size() < DEPTH)) && (exp_State == m_st) &&
           (err == m_err) && (int'(err_cnt) == m_errcnt) &&
           (int'(err_cycle) == m_errcyc) && (int'(cycle_cnt) == m_cyc);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL cycle_model t=%0t got ABR=%b%b%b busy=%b rdy=%b st=%b err=%b ecnt=%0d ecyc=%0d cyc=%0d want ABR=%b%b%b busy=%b rdy=%b st=%b err=%b ecnt=%0d ecyc=%0d cyc=%0d",
                  $time, A, B, R, busy, cmd_ready, exp_State, err, err_cnt, err_cycle, cycle_cnt,
                  m_a, m_b, m_r, (m_play || q.size() != 0), (q.size() < DEPTH), m_st, m_err,
                  m_errcnt, m_errcyc, m_cyc);
      end
   endtask

   task automatic check(input string name, input int act, input int want);
      n_cmp++;
      if (act != want) begin
         n_bad++;
         $display("FAIL %s got %0d want %0d", name, act, want);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (reset_n) check_cycle();
   endtask

   task automatic push(input logic a, input logic b, input logic r, input int hold);
      int w;
      w = 0;
      cmd_valid = 1'b1;
      cmd_a = a; cmd_b = b; cmd_r = r; cmd_hold = HOLDW'(hold);
      while (!cmd_ready && w < 300) begin tick(); w++; end
      if (!cmd_ready) check("push_timeout", 0, 1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while (busy && w < 300) begin tick(); w++; end
      if (busy) check("idle_timeout", 0, 1);
      tick();
      tick();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      do_reset();
      tick();
      check("rst_abr",    int'({A, B, R}), 0);
      check("rst_busy",   int'(busy), 0);
      check("rst_ready",  int'(cmd_ready), 1);
      check("rst_state",  int'(exp_State), 0);
      check("rst_err",    int'(err), 0);
      check("rst_cycles", int'(cycle_cnt), 0);
      check("rst_errcnt", int'(err_cnt), 0);

      // A, then B, then idle levels for 2; first drive lands 2 cycles after push
      push(1, 0, 0, 1);
      check("latency_a_low", int'(A), 0);
      push(0, 1, 0, 1);
      check("latency_a_high", int'(A), 1);
      push(0, 0, 0, 2);
      check("seq_state_after_a", int'(exp_State), 1);
      wait_idle();
      check("seq_state",  int'(exp_State), 3);
      check("seq_cycles", int'(cycle_cnt), 5);
      check("seq_errcnt", int'(err_cnt), 0);

      // A&B together, then R with hold 0 (plays one cycle)
      push(1, 1, 0, 1);
      push(0, 0, 1, 0);
      wait_idle();
      check("sim_state",  int'(exp_State), 0);
      check("sim_cycles", int'(cycle_cnt), 8);
      check("sim_err",    int'(err), 0);

      // State stuck at 00 while A then B play
      do_reset();
      force_zero = 1'b1;
      push(1, 0, 0, 2);
      push(0, 1, 0, 2);
      wait_idle();
      force_zero = 1'b0;
      check("flt_err",    int'(err), 1);
      check("flt_errcyc", int'(err_cycle), 1);
      check("flt_errcnt", int'(err_cnt), 4);
      check("flt_cycles", int'(cycle_cnt), 5);

      // Overflow the FIFO behind a long hold; playback must be gapless
      do_reset();
      push(1, 0, 0, 20);
      push(0, 1, 0, 1);
      push(0, 0, 1, 2);
      push(1, 1, 0, 3);
      push(0, 0, 0, 4);
      check("ovf_ready_low", int'(cmd_ready), 0);
      check("ovf_busy",      int'(busy), 1);
      push(0, 1, 0, 1);
      wait_idle();
      check("ovf_cycles", int'(cycle_cnt), 32);
      check("ovf_errcnt", int'(err_cnt), 0);

      // Reset in the middle of a hold with two entries queued
      push(1, 0, 0, 30);
      push(0, 1, 0, 3);
      push(0, 0, 1, 3);
      repeat (3) tick();
      reset_n = 1'b0;
      #1;
      check("mid_abr",    int'({A, B, R}), 0);
      check("mid_busy",   int'(busy), 0);
      check("mid_ready",  int'(cmd_ready), 1);
      check("mid_cycles", int'(cycle_cnt), 0);
      tick();
      reset_n = 1'b1;
      repeat (10) tick();
      check("post_abr",   int'({A, B, R}), 0);
      check("post_busy",  int'(busy), 0);
      check("post_cycles", int'(cycle_cnt), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/abro_stim_driver.md
Name: abro_stim_driver

Overview:
- Active stimulus/response end of the ABRO state-machine interface: drives A, B and R into an ABRO DUT and checks the DUT's O and State against an internal reference model.
- A host pushes timed drive commands into a small command FIFO. The driver plays each command for a programmed number of cycles.
- Every cycle, the DUT response is compared with the model. Mismatches are counted and the first failure is captured.
- Used as the synthesizable replacement for hand-written ABRO testbench stimulus.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, at least 2).
- HOLDW, 8, width of the per-command hold-cycle count.
- CNTW, 16, width of the cycle and mismatch counters.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  host command present.
- cmd_ready  out  1  FIFO not full; a push occurs when cmd_valid && cmd_ready.
- cmd_a  in  1  A level to drive.
- cmd_b  in  1  B level to drive.
- cmd_r  in  1  R (synchronous DUT reset) level to drive.
- cmd_hold  in  HOLDW  cycles to hold the levels; 0 is treated as 1.
- A  out  1  stimulus to DUT.
- B  out  1  stimulus to DUT.
- R  out  1  stimulus to DUT.
- dut_O  in  1  DUT output O.
- dut_State  in  2  DUT state.
- busy  out  1  a command is playing or the FIFO is non-empty.
- cycle_cnt  out  CNTW  cycles played since reset; saturating.
- err_cnt  out  CNTW  mismatch count; saturating.
- err  out  1  sticky; set on the first mismatch.
- err_cycle  out  CNTW  cycle_cnt value at the first mismatch.
- exp_State  out  2  model state, for waveform debug.

Behaviour:
- Reset (reset_n=0, asynchronous) clears:
  - A, B, R, busy, err to 0;
  - the FIFO to empty (cmd_ready=1);
  - cycle_cnt, err_cnt, err_cycle to 0;
  - the model to S_IDLE (exp_State=00).
- FIFO:
  - cmd_ready = !full.
  - A push when full is impossible because cmd_ready=0.
  - A simultaneous push and pop when full is not allowed (cmd_ready already low). A simultaneous push and pop when non-full is legal and leaves the count unchanged.
- Player FSM states:
  - P_IDLE: A=B=R=0, held. If the FIFO is non-empty, pop and load levels/hold into registers; go to P_PLAY next cycle.
  - P_PLAY: A/B/R registered outputs equal the loaded levels. The hold counter decrements each cycle.
  - At the last hold cycle: if the FIFO is non-empty, pop and load the next command so levels change with no gap cycle; otherwise go to P_IDLE, and outputs return to 0 on the next cycle.
  - Command latency: a push into an empty FIFO while in P_IDLE appears on A/B/R 2 cycles later.
- Reference model (mirrors the DUT; updates on the same edge that the DUT samples A/B/R), evaluated in priority order:
  - R=1 -> S_IDLE (00).
  - S_IDLE: A&B->S_DONE(11); A->S_A(01); B->S_B(10).
  - S_A: B->S_DONE.
  - S_B: A->S_DONE.
  - S_DONE stays until R.
  - Expected O = (state==S_DONE).
- Checking:
  - Active on every cycle in P_PLAY, and on the single cycle after the last played cycle (the response to the final drive).
  - Compare dut_O vs expected O and dut_State vs exp_State; mismatch if either differs.
  - On mismatch: err_cnt+1 (saturate at all-ones). If err was 0: set err and capture err_cycle.
  - cycle_cnt increments on each checked cycle (saturate).
  - No checking in P_IDLE. The model still tracks A/B/R=0, so state is held.
- busy = (player != P_IDLE) || !empty.
- reset_n asserted mid-command aborts playback, discards FIFO contents and returns all outputs to reset values immediately.

Decomposition:
- Shared package abro_pkg holds:
  - state encodings S_IDLE=2'b00, S_A=2'b01, S_B=2'b10, S_DONE=2'b11;
  - player encodings P_IDLE, P_PLAY;
  - a next-state function usable by both the DUT and this model.
- One natural sub-module: abro_cmd_fifo (synchronous, DEPTH x (3+HOLDW), full/empty flags).
- Model and player stay inline in abro_stim_driver.

Test Plan:
- Reset check: after reset with no commands -> A=B=R=0, busy=0, cmd_ready=1, exp_State=00, err=0, counters 0.
- Sequence {A=1 hold 1}, {B=1 hold 1}, {A=B=0 hold 2} against a correct DUT -> exp_State goes 01,11,11,11; O high from the B cycle on; err_cnt=0; cycle_cnt=5.
- Simultaneous: {A=1,B=1 hold 1}, then {R=1 hold 1} -> exp_State 11 then 00; hold=0 behaves as 1.
- Injected fault (DUT forced to State=00 while A/B are driven) -> err=1, err_cycle equals the first divergent checked cycle, err_cnt counts each bad cycle.
- Push 5 commands with DEPTH=4 while the player is stalled by a long hold -> cmd_ready drops after 4; playback is back-to-back with no idle gap.
- Assert reset_n low mid-hold with the FIFO holding 2 entries -> outputs go to 0 immediately; after release, busy=0 and no stale command plays.
